// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/sequencing controller.
package pipe_ctrl_pkg;

    localparam int unsigned DIV_CYCLES_DEF = 32;
    localparam int unsigned CNT_W_DEF      = 6;
    localparam int unsigned STALL_W        = 6;
    localparam int unsigned STALL_CNT_W    = 32;
    localparam int unsigned ALUOP_W        = 6;

    // Stall vector bits: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

    localparam logic [ALUOP_W-1:0] ALUOP_NOP  = 6'b000000;
    localparam logic [ALUOP_W-1:0] ALUOP_DIV  = 6'b011010;
    localparam logic [ALUOP_W-1:0] ALUOP_DIVU = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic               load;
        logic               step;
        logic               done;
        logic               busy;
        logic [STALL_W-1:0] stall;
    } ctrl_out_t;

    // ex uses this to raise ex_div_start_i for div/divu
    function automatic logic is_div_op(input logic [ALUOP_W-1:0] aluop);
        return (aluop == ALUOP_DIV) || (aluop == ALUOP_DIVU);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall controller.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                   id_stallreq_i;
    logic                   ex_div_start_i;
    logic                   ex_div_zero_i;
    logic                   ex_cancel_i;
    logic                   div_load_o;
    logic                   div_step_o;
    logic                   div_done_o;
    logic                   div_busy_o;
    logic [STALL_W-1:0]     stall_o;
    logic [STALL_CNT_W-1:0] stall_cnt_o;

    modport master (
        output id_stallreq_i, ex_div_start_i, ex_div_zero_i, ex_cancel_i,
        input  div_load_o, div_step_o, div_done_o, div_busy_o, stall_o, stall_cnt_o
    );

    modport slave (
        input  id_stallreq_i, ex_div_start_i, ex_div_zero_i, ex_cancel_i,
        output div_load_o, div_step_o, div_done_o, div_busy_o, stall_o, stall_cnt_o
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous active-high reset.
module pipe_ctrl_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: merges load-use stalls with an iterative divide sequencer
// and counts stalled cycles for performance debug.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    state_e                 state_q;
    state_e                 state_d;
    logic [CNT_W-1:0]       iter_q;
    logic [CNT_W-1:0]       iter_d;
    ctrl_out_t              out_c;
    logic                   ex_req_c;
    logic [STALL_CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // Next state: DONE is left unconditionally so a held start cannot re-launch the same div.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ex_div_start_i && !bus.ex_cancel_i) begin
                    state_d = bus.ex_div_zero_i ? ST_DONE : ST_BUSY;
                    iter_d  = '0;
                end
            end
            ST_BUSY: begin
                if (bus.ex_cancel_i) begin
                    state_d = ST_IDLE;
                end else begin
                    iter_d = iter_q + CNT_W'(1);
                    if (iter_q == CNT_W'(DIV_CYCLES - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: a cancelled cycle raises neither an ex stall nor a divider pulse.
    always_comb begin
        out_c    = '0;
        ex_req_c = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ex_div_start_i && !bus.ex_cancel_i) begin
                        out_c.load = 1'b1;
                        ex_req_c   = 1'b1;
                    end
                end
                ST_BUSY: begin
                    out_c.busy = 1'b1;
                    if (!bus.ex_cancel_i) begin
                        out_c.step = 1'b1;
                        ex_req_c   = 1'b1;
                    end
                end
                ST_DONE: begin
                    out_c.busy = 1'b1;
                    out_c.done = !bus.ex_cancel_i;
                end
                default: ;
            endcase
            if (ex_req_c) begin
                out_c.stall = STALL_EX;
            end else if (bus.id_stallreq_i) begin
                out_c.stall = STALL_ID;
            end else begin
                out_c.stall = STALL_NONE;
            end
        end
    end

    pipe_ctrl_sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (out_c.stall != STALL_NONE),
        .cnt_o (stall_cnt)
    );

    assign bus.div_load_o  = out_c.load;
    assign bus.div_step_o  = out_c.step;
    assign bus.div_done_o  = out_c.done;
    assign bus.div_busy_o  = out_c.busy;
    assign bus.stall_o     = out_c.stall;
    assign bus.stall_cnt_o = rst ? '0 : stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with an expected-output queue and a stall-count model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    typedef struct {
        string      tag;
        logic [5:0] stall;
        logic       load;
        logic       step;
        logic       done;
        logic       busy;
    } exp_t;

    logic        clk;
    logic        rst;
    exp_t        sb[$];
    int          total;
    int          bad;
    logic [31:0] exp_cnt;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .DIV_CYCLES (32),
        .CNT_W      (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at posedge+1, compare combinational outputs at negedge, counter after the edge.
    task automatic step(input logic [5:0] aluop, input logic zero, input logic cancel,
                        input logic idreq, input logic [5:0] e_stall, input logic e_load,
                        input logic e_step, input logic e_done, input logic e_busy,
                        input string tag);
        exp_t e;
        bus.ex_div_start_i = is_div_op(aluop);
        bus.ex_div_zero_i  = zero;
        bus.ex_cancel_i    = cancel;
        bus.id_stallreq_i  = idreq;
        e.tag   = tag;
        e.stall = e_stall;
        e.load  = e_load;
        e.step  = e_step;
        e.done  = e_done;
        e.busy  = e_busy;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check({e.tag, ".stall"}, 32'(bus.stall_o), 32'(e.stall));
        check({e.tag, ".load"},  32'(bus.div_load_o), 32'(e.load));
        check({e.tag, ".step"},  32'(bus.div_step_o), 32'(e.step));
        check({e.tag, ".done"},  32'(bus.div_done_o), 32'(e.done));
        check({e.tag, ".busy"},  32'(bus.div_busy_o), 32'(e.busy));
        @(posedge clk);
        if (rst) begin
            exp_cnt = '0;
        end else if ((e.stall != 6'd0) && (exp_cnt != 32'hFFFF_FFFF)) begin
            exp_cnt = exp_cnt + 32'd1;
        end
        #1;
        check({e.tag, ".cnt"}, bus.stall_cnt_o, exp_cnt);
    endtask

    task automatic idle(input string tag);
        step(ALUOP_NOP, 1'b0, 1'b0, 1'b0, STALL_NONE, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    // Full-length divide with start held in ex until DONE.
    task automatic div_run(input logic [5:0] aluop, input logic idreq, input logic idreq_done,
                           input string tag);
        step(aluop, 1'b0, 1'b0, idreq, STALL_EX, 1'b1, 1'b0, 1'b0, 1'b0, {tag, ".load"});
        for (int i = 1; i <= 32; i++) begin
            step(aluop, 1'b0, 1'b0, idreq, STALL_EX, 1'b0, 1'b1, 1'b0, 1'b1,
                 $sformatf("%s.it%0d", tag, i));
        end
        step(aluop, 1'b0, 1'b0, idreq_done, idreq_done ? STALL_ID : STALL_NONE,
             1'b0, 1'b0, 1'b1, 1'b1, {tag, ".done"});
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_cnt = '0;
        rst     = 1'b1;

        // reset with start and id stall asserted
        step(ALUOP_DIV, 1'b0, 1'b0, 1'b1, STALL_NONE, 1'b0, 1'b0, 1'b0, 1'b0, "rst0");
        step(ALUOP_DIV, 1'b0, 1'b0, 1'b1, STALL_NONE, 1'b0, 1'b0, 1'b0, 1'b0, "rst1");
        rst = 1'b0;
        idle("post_rst");
        check("post_rst.cnt_zero", bus.stall_cnt_o, 32'd0);

        // plain divide: 33 stall cycles then done
        div_run(ALUOP_DIV, 1'b0, 1'b0, "div");
        idle("div.after");
        check("div.cnt33", bus.stall_cnt_o, 32'd33);

        // divide by zero: one stall cycle, done next, no iteration
        step(ALUOP_DIVU, 1'b1, 1'b0, 1'b0, STALL_EX, 1'b1, 1'b0, 1'b0, 1'b0, "dz.load");
        step(ALUOP_DIVU, 1'b1, 1'b0, 1'b0, STALL_NONE, 1'b0, 1'b0, 1'b1, 1'b1, "dz.done");
        idle("dz.after");
        check("dz.cnt34", bus.stall_cnt_o, 32'd34);

        // id stall alone, then ex priority over id, then id visible at DONE
        step(ALUOP_NOP, 1'b0, 1'b0, 1'b1, STALL_ID, 1'b0, 1'b0, 1'b0, 1'b0, "id_only");
        div_run(ALUOP_DIV, 1'b1, 1'b1, "prio");
        idle("prio.after");

        // cancel at iteration 10, then a fresh full-length divide
        step(ALUOP_DIV, 1'b0, 1'b0, 1'b0, STALL_EX, 1'b1, 1'b0, 1'b0, 1'b0, "cxl.load");
        for (int i = 1; i <= 10; i++) begin
            step(ALUOP_DIV, 1'b0, 1'b0, 1'b0, STALL_EX, 1'b0, 1'b1, 1'b0, 1'b1,
                 $sformatf("cxl.it%0d", i));
        end
        step(ALUOP_DIV, 1'b0, 1'b1, 1'b0, STALL_NONE, 1'b0, 1'b0, 1'b0, 1'b1, "cxl.cancel");
        idle("cxl.idle0");
        idle("cxl.idle1");
        div_run(ALUOP_DIVU, 1'b0, 1'b0, "fresh");
        idle("fresh.after");

        // saturation of the stall-cycle counter
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.cnt_q;
        exp_cnt = 32'hFFFF_FFFE;
        check("sat.preset", bus.stall_cnt_o, exp_cnt);
        for (int i = 0; i < 3; i++) begin
            step(ALUOP_NOP, 1'b0, 1'b0, 1'b1, STALL_ID, 1'b0, 1'b0, 1'b0, 1'b0,
                 $sformatf("sat%0d", i));
        end
        check("sat.hold", bus.stall_cnt_o, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
